// File: rtl/multicycle_decoder_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit:
// FSM state codes, instruction Op field codes, data-processing cmd codes
// and ALUControl codes.
package multicycle_decoder_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // CMP with S set: a flags-only compare that produces no register result.
  function automatic logic is_cmp_s(input logic [5:0] funct);
    return (funct[4:1] == CMD_CMP) && funct[0];
  endfunction

endpackage

// File: rtl/multicycle_decoder_alu_decoder.sv
// Combinational ALU decode: maps ALUOp and Funct onto ALUControl and the
// pre-condition flag-write request. Unknown cmds fall back to ADD so the
// outputs are never X. Optional CMP support is selected by CMP_NOWRITE_EN.
module alu_decoder
  import multicycle_decoder_pkg::*;
(
  input  logic       ALUOp,
  input  logic [5:0] Funct,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  // Select ALU operation and flag-write pattern from cmd and S
  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (ALUOp) begin
      unique case (cmd)
        CMD_ADD: ALUControl = ALU_ADD;
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      // NZ follows S for every cmd; CV only for arithmetic
      FlagW[1] = s_bit;
      FlagW[0] = s_bit && ((cmd == CMD_ADD) || (cmd == CMD_SUB));
`ifdef CMP_NOWRITE_EN
      if (is_cmp_s(Funct)) begin
        ALUControl = ALU_SUB;
        FlagW      = 2'b11;
      end
`endif
    end
  end

endmodule

// File: rtl/multicycle_decoder.sv
// Multicycle ARM-subset main FSM. Sequences fetch/decode/execute/writeback
// and produces mux selects plus pre-condition write strobes for the
// conditional-write unit. Optional macro CMP_NOWRITE_EN makes CMP (S=1)
// skip ALUWB. Strobes are forced low while reset is high.
module multicycle_decoder
  import multicycle_decoder_pkg::*;
#(
  parameter logic [3:0] PC_REG  = 4'd15,
  parameter int         STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  logic [STATE_W-1:0] state_q, state_d;

  logic       irw_s, npc_s, regw_s, memw_s, branch_s, aluop_s;
  logic [1:0] flagw_s;

  // State register; asynchronous reset returns to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection from current state and IR fields
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_B:    state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI: begin
`ifdef CMP_NOWRITE_EN
        state_d = is_cmp_s(Funct) ? S_FETCH : S_ALUWB;
`else
        state_d = S_ALUWB;
`endif
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; unreachable encodings drive everything low
  always_comb begin
    irw_s     = 1'b0;
    npc_s     = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    branch_s  = 1'b0;
    aluop_s   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        irw_s = 1'b1; npc_s = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01; regw_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1; memw_s = 1'b1;
      end
      S_EXECUTER: aluop_s = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01; aluop_s = 1'b1;
      end
      S_ALUWB:    regw_s = 1'b1;
      S_BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; branch_s = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (aluop_s),
    .Funct      (Funct),
    .ALUControl (ALUControl),
    .FlagW      (flagw_s)
  );

  // Strobes are held low for the whole time reset is asserted
  assign IRWrite = irw_s  & ~reset;
  assign NextPC  = npc_s  & ~reset;
  assign RegW    = regw_s & ~reset;
  assign MemW    = memw_s & ~reset;
  assign FlagW   = flagw_s & {2{~reset}};
  assign PCS     = ((branch_s & ~reset) | (RegW & (Rd == PC_REG)));

  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == OP_MEM), (Op == OP_B)};

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed bench for multicycle_decoder: each cycle pushes the expected
// output vector onto a scoreboard; a negedge checker pops and compares.
module tb_multicycle_decoder;

  logic       clk, reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

  multicycle_decoder dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3,
                 T_MEMREAD = 4, T_MEMWB = 5, T_MEMWRITE = 6, T_EXR = 7,
                 T_EXI = 8, T_ALUWB = 9, T_BRANCH = 10;

  typedef struct {
    logic [18:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  logic [18:0] obs;
  assign obs = {PCS, NextPC, RegW, MemW, FlagW, IRWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};

  // Expected output vector from the state table, with PCS/ALU/flags given
  function automatic logic [18:0] ev(input int st, input logic pcs,
                                     input logic [1:0] alu, input logic [1:0] fw,
                                     input logic [1:0] op);
    logic npc, rw, mw, irw, adr, sa;
    logic [1:0] sbm, rs;
    npc = 0; rw = 0; mw = 0; irw = 0; adr = 0; sa = 0; sbm = 2'b00; rs = 2'b00;
    case (st)
      T_RST:      begin sa = 1; sbm = 2'b10; rs = 2'b10; end
      T_FETCH:    begin irw = 1; npc = 1; sa = 1; sbm = 2'b10; rs = 2'b10; end
      T_DECODE:   begin sa = 1; sbm = 2'b10; rs = 2'b10; end
      T_MEMADR:   sbm = 2'b01;
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin rs = 2'b01; rw = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; end
      T_EXR:      sbm = 2'b00;
      T_EXI:      sbm = 2'b01;
      T_ALUWB:    rw = 1;
      T_BRANCH:   begin sbm = 2'b01; rs = 2'b10; end
      default: ;
    endcase
    return {pcs, npc, rw, mw, fw, irw, adr, sa, sbm, rs, alu, op,
            (op == 2'b01), (op == 2'b10)};
  endfunction

  task automatic check(input string tag, input logic [18:0] o, input logic [18:0] x);
    n_chk++;
    assert (o === x) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  // One cycle of stimulus: drive after the edge, push the expectation
  task automatic cyc(input logic r, input logic [1:0] op, input logic [5:0] f,
                     input logic [3:0] rd, input int st, input logic pcs,
                     input logic [1:0] alu, input logic [1:0] fw, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; Op = op; Funct = f; Rd = rd;
    e.v = ev(st, pcs, alu, fw, op);
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs, e.v);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'b001000; Rd = 4'd3;
    // Reset held three cycles
    cyc(1, 2'b00, 6'b001000, 4'd3, T_RST, 0, 2'b00, 2'b00, "rst1");
    cyc(1, 2'b00, 6'b001000, 4'd3, T_RST, 0, 2'b00, 2'b00, "rst2");
    cyc(1, 2'b00, 6'b001000, 4'd3, T_RST, 0, 2'b00, 2'b00, "rst3");
    // ADD immediate, Rd=3
    cyc(0, 2'b00, 6'b101000, 4'd3, T_FETCH,  0, 2'b00, 2'b00, "addi_fetch");
    cyc(0, 2'b00, 6'b101000, 4'd3, T_DECODE, 0, 2'b00, 2'b00, "addi_decode");
    cyc(0, 2'b00, 6'b101000, 4'd3, T_EXI,    0, 2'b00, 2'b00, "addi_exec");
    cyc(0, 2'b00, 6'b101000, 4'd3, T_ALUWB,  0, 2'b00, 2'b00, "addi_wb");
    // LDR to PC
    cyc(0, 2'b01, 6'b011001, 4'd15, T_FETCH,   0, 2'b00, 2'b00, "ldr_fetch");
    cyc(0, 2'b01, 6'b011001, 4'd15, T_DECODE,  0, 2'b00, 2'b00, "ldr_decode");
    cyc(0, 2'b01, 6'b011001, 4'd15, T_MEMADR,  0, 2'b00, 2'b00, "ldr_adr");
    cyc(0, 2'b01, 6'b011001, 4'd15, T_MEMREAD, 0, 2'b00, 2'b00, "ldr_read");
    cyc(0, 2'b01, 6'b011001, 4'd15, T_MEMWB,   1, 2'b00, 2'b00, "ldr_wb");
    // STR
    cyc(0, 2'b01, 6'b011000, 4'd2, T_FETCH,    0, 2'b00, 2'b00, "str_fetch");
    cyc(0, 2'b01, 6'b011000, 4'd2, T_DECODE,   0, 2'b00, 2'b00, "str_decode");
    cyc(0, 2'b01, 6'b011000, 4'd2, T_MEMADR,   0, 2'b00, 2'b00, "str_adr");
    cyc(0, 2'b01, 6'b011000, 4'd2, T_MEMWRITE, 0, 2'b00, 2'b00, "str_write");
    // SUBS register
    cyc(0, 2'b00, 6'b000101, 4'd4, T_FETCH,  0, 2'b00, 2'b00, "subs_fetch");
    cyc(0, 2'b00, 6'b000101, 4'd4, T_DECODE, 0, 2'b00, 2'b00, "subs_decode");
    cyc(0, 2'b00, 6'b000101, 4'd4, T_EXR,    0, 2'b01, 2'b11, "subs_exec");
    cyc(0, 2'b00, 6'b000101, 4'd4, T_ALUWB,  0, 2'b00, 2'b00, "subs_wb");
    // ORRS register to PC
    cyc(0, 2'b00, 6'b011001, 4'd15, T_FETCH,  0, 2'b00, 2'b00, "orrs_fetch");
    cyc(0, 2'b00, 6'b011001, 4'd15, T_DECODE, 0, 2'b00, 2'b00, "orrs_decode");
    cyc(0, 2'b00, 6'b011001, 4'd15, T_EXR,    0, 2'b11, 2'b10, "orrs_exec");
    cyc(0, 2'b00, 6'b011001, 4'd15, T_ALUWB,  1, 2'b00, 2'b00, "orrs_wb");
    // ANDS immediate
    cyc(0, 2'b00, 6'b100001, 4'd5, T_FETCH,  0, 2'b00, 2'b00, "ands_fetch");
    cyc(0, 2'b00, 6'b100001, 4'd5, T_DECODE, 0, 2'b00, 2'b00, "ands_decode");
    cyc(0, 2'b00, 6'b100001, 4'd5, T_EXI,    0, 2'b10, 2'b10, "ands_exec");
    cyc(0, 2'b00, 6'b100001, 4'd5, T_ALUWB,  0, 2'b00, 2'b00, "ands_wb");
    // Unknown cmd 0111 with S
    cyc(0, 2'b00, 6'b001111, 4'd6, T_FETCH,  0, 2'b00, 2'b00, "unk_fetch");
    cyc(0, 2'b00, 6'b001111, 4'd6, T_DECODE, 0, 2'b00, 2'b00, "unk_decode");
    cyc(0, 2'b00, 6'b001111, 4'd6, T_EXR,    0, 2'b00, 2'b10, "unk_exec");
    cyc(0, 2'b00, 6'b001111, 4'd6, T_ALUWB,  0, 2'b00, 2'b00, "unk_wb");
    // CMP with S, Rd=15 so a stray writeback would also raise PCS
    cyc(0, 2'b00, 6'b010101, 4'd15, T_FETCH,  0, 2'b00, 2'b00, "cmp_fetch");
    cyc(0, 2'b00, 6'b010101, 4'd15, T_DECODE, 0, 2'b00, 2'b00, "cmp_decode");
`ifdef CMP_NOWRITE_EN
    cyc(0, 2'b00, 6'b010101, 4'd15, T_EXR,    0, 2'b01, 2'b11, "cmp_exec");
`else
    cyc(0, 2'b00, 6'b010101, 4'd15, T_EXR,    0, 2'b00, 2'b10, "cmp_exec");
    cyc(0, 2'b00, 6'b010101, 4'd15, T_ALUWB,  1, 2'b00, 2'b00, "cmp_wb");
`endif
    // Branch
    cyc(0, 2'b10, 6'b101000, 4'd0, T_FETCH,  0, 2'b00, 2'b00, "b_fetch");
    cyc(0, 2'b10, 6'b101000, 4'd0, T_DECODE, 0, 2'b00, 2'b00, "b_decode");
    cyc(0, 2'b10, 6'b101000, 4'd0, T_BRANCH, 1, 2'b00, 2'b00, "b_branch");
    // Op=11 no-op
    cyc(0, 2'b11, 6'b000000, 4'd15, T_FETCH,  0, 2'b00, 2'b00, "nop_fetch");
    cyc(0, 2'b11, 6'b000000, 4'd15, T_DECODE, 0, 2'b00, 2'b00, "nop_decode");
    // STR interrupted by asynchronous reset in MEMWRITE
    cyc(0, 2'b01, 6'b011000, 4'd2, T_FETCH,    0, 2'b00, 2'b00, "str2_fetch");
    cyc(0, 2'b01, 6'b011000, 4'd2, T_DECODE,   0, 2'b00, 2'b00, "str2_decode");
    cyc(0, 2'b01, 6'b011000, 4'd2, T_MEMADR,   0, 2'b00, 2'b00, "str2_adr");
    cyc(0, 2'b01, 6'b011000, 4'd2, T_MEMWRITE, 0, 2'b00, 2'b00, "str2_write");
    #5;
    reset = 1'b1;
    #1;
    check("async_rst", obs, ev(T_RST, 0, 2'b00, 2'b00, 2'b01));
    cyc(1, 2'b00, 6'b001000, 4'd15, T_RST,   0, 2'b00, 2'b00, "rst_hold");
    // ADD register to PC after release
    cyc(0, 2'b00, 6'b001000, 4'd15, T_FETCH,  0, 2'b00, 2'b00, "add_fetch");
    cyc(0, 2'b00, 6'b001000, 4'd15, T_DECODE, 0, 2'b00, 2'b00, "add_decode");
    cyc(0, 2'b00, 6'b001000, 4'd15, T_EXR,    0, 2'b00, 2'b00, "add_exec");
    cyc(0, 2'b00, 6'b001000, 4'd15, T_ALUWB,  1, 2'b00, 2'b00, "add_wb");
    cyc(0, 2'b00, 6'b001000, 4'd15, T_FETCH,  0, 2'b00, 2'b00, "next_fetch");
    @(negedge clk);
    #1;
    n_chk++;
    assert (sb.size() == 0) n_pass++;
    else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
